uart_tx_arbiter: RTL and testbench

- Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
- Grants one requester, captures its byte, and pulses tx_start to the transmitter.
- Holds the grant until the transmitter reports frame completion, then re-arbitrates.
- Sits between the requester valid/ready interfaces and the transmitter's start/busy/done interface.

---
 rtl/uart_tx_arbiter.sv | 130 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional watchdog abort is built when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_start,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          arb_active,
  output logic                          arb_timeout
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("uart_tx_arbiter: unsupported parameter value");
  end

  typedef enum logic [3:0] {
    ARB_IDLE      = 4'b0001,
    ARB_START     = 4'b0010,
    ARB_WAIT_BUSY = 4'b0100,
    ARB_WAIT_DONE = 4'b1000
  } state_t;

  state_t                  state, state_next;
  logic [IW-1:0]           rr_ptr;
  logic [IW-1:0]           winner;
  logic [IW-1:0]           cand;
  logic [IW-1:0]           rr_next;
  logic                    any_valid;
  logic                    grant;
  logic                    waiting;
  logic                    expired;
  logic [DATA_WIDTH-1:0]   win_data;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    any_valid = 1'b0;
    winner    = '0;
    cand      = rr_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
      cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == IW'(i)) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rr_next    = (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
  assign grant      = (state == ARB_IDLE) && any_valid;
  assign waiting    = (state == ARB_WAIT_BUSY) || (state == ARB_WAIT_DONE);
  assign arb_active = (state != ARB_IDLE);
  // Gated by rst_n so a requester held valid through reset sees no accept.
  assign req_ready  = (grant && rst_n) ? (NUM_REQ'(1) << winner) : '0;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0] wd_cnt;

  assign expired = waiting && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt      <= '0;
      arb_timeout <= 1'b0;
    end else begin
      arb_timeout <= expired && !tx_done;
      if (state == ARB_START) wd_cnt <= '0;
      else if (waiting)       wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign expired     = 1'b0;
  assign arb_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:      if (any_valid) state_next = ARB_START;
      ARB_START:     state_next = ARB_WAIT_BUSY;
      ARB_WAIT_BUSY: begin
        if (tx_done || expired) state_next = ARB_IDLE;
        else if (tx_busy)       state_next = ARB_WAIT_DONE;
      end
      ARB_WAIT_DONE: if (tx_done || expired) state_next = ARB_IDLE;
      default:       state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      grant_id <= '0;
    end else begin
      tx_start <= grant;
      if (grant) begin
        tx_data  <= win_data;
        grant_id <= winner;
        rr_ptr   <= rr_next;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed table, hand sequences,
// and randomized traffic against a transaction-level reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO    = 16;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TO    = 1024;
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   tx_data;
  logic            tx_start;
  logic            tx_busy;
  logic            tx_done;
  logic [IW-1:0]   grant_id;
  logic            arb_active;
  logic            arb_timeout;

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .grant_id(grant_id),
    .arb_active(arb_active),
    .arb_timeout(arb_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       busy;
    logic       done;
    logic [3:0] ready;
    logic       start;
    logic [7:0] data;
    logic [1:0] gid;
    logic       active;
  } vec_t;

  vec_t tbl[24];

  initial begin
    logic [3:0] pend;
    logic [7:0] pdat[4];
    int         m_rr, m_age, m_gid, w, idx;
    bit         m_in, m_to, m_to_n;
    logic [7:0] m_data;
    logic [3:0] e_ready;

    // valid busy done | ready start data gid active
    tbl[0]  = '{4'hF, 0, 0, 4'b0001, 0, 8'h00, 0, 0};
    tbl[1]  = '{4'hF, 0, 0, 4'b0000, 1, 8'h10, 0, 1};
    tbl[2]  = '{4'hF, 0, 1, 4'b0000, 0, 8'h10, 0, 1};
    tbl[3]  = '{4'hF, 0, 0, 4'b0010, 0, 8'h10, 0, 0};
    tbl[4]  = '{4'hF, 0, 0, 4'b0000, 1, 8'h11, 1, 1};
    tbl[5]  = '{4'hF, 1, 0, 4'b0000, 0, 8'h11, 1, 1};
    tbl[6]  = '{4'hF, 1, 1, 4'b0000, 0, 8'h11, 1, 1};
    tbl[7]  = '{4'hF, 0, 0, 4'b0100, 0, 8'h11, 1, 0};
    tbl[8]  = '{4'hF, 0, 0, 4'b0000, 1, 8'h12, 2, 1};
    tbl[9]  = '{4'hF, 0, 1, 4'b0000, 0, 8'h12, 2, 1};
    tbl[10] = '{4'hF, 0, 0, 4'b1000, 0, 8'h12, 2, 0};
    tbl[11] = '{4'hF, 0, 0, 4'b0000, 1, 8'h13, 3, 1};
    tbl[12] = '{4'hF, 0, 1, 4'b0000, 0, 8'h13, 3, 1};
    tbl[13] = '{4'h9, 0, 0, 4'b0001, 0, 8'h13, 3, 0};
    tbl[14] = '{4'h9, 0, 0, 4'b0000, 1, 8'h10, 0, 1};
    tbl[15] = '{4'h9, 0, 1, 4'b0000, 0, 8'h10, 0, 1};
    tbl[16] = '{4'h9, 0, 0, 4'b1000, 0, 8'h10, 0, 0};
    tbl[17] = '{4'h9, 0, 1, 4'b0000, 1, 8'h13, 3, 1};
    tbl[18] = '{4'h1, 0, 0, 4'b0000, 0, 8'h13, 3, 1};
    tbl[19] = '{4'h1, 0, 1, 4'b0000, 0, 8'h13, 3, 1};
    tbl[20] = '{4'h1, 0, 1, 4'b0001, 0, 8'h13, 3, 0};
    tbl[21] = '{4'h0, 0, 0, 4'b0000, 1, 8'h10, 0, 1};
    tbl[22] = '{4'h0, 0, 1, 4'b0000, 0, 8'h10, 0, 1};
    tbl[23] = '{4'h0, 0, 0, 4'b0000, 0, 8'h10, 0, 0};

    req_data = '0;
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    #1;
    chk("reset tx_start", tx_start, 0);
    chk("reset tx_data", tx_data, 0);
    chk("reset grant_id", grant_id, 0);
    chk("reset arb_active", arb_active, 0);
    chk("reset arb_timeout", arb_timeout, 0);
    chk("reset req_ready", req_ready, 0);

    // Directed round-robin, wrap, fast-tx and ignored-done table.
    do_reset();
    req_data = 32'h13121110;
    for (int i = 0; i < 24; i++) begin
      req_valid = tbl[i].valid;
      tx_busy   = tbl[i].busy;
      tx_done   = tbl[i].done;
      #1;
      chk($sformatf("tbl%0d req_ready", i), req_ready, tbl[i].ready);
      chk($sformatf("tbl%0d tx_start", i), tx_start, tbl[i].start);
      chk($sformatf("tbl%0d tx_data", i), tx_data, tbl[i].data);
      chk($sformatf("tbl%0d grant_id", i), grant_id, tbl[i].gid);
      chk($sformatf("tbl%0d arb_active", i), arb_active, tbl[i].active);
      chk($sformatf("tbl%0d arb_timeout", i), arb_timeout, 0);
      @(negedge clk);
    end

    // Single request with a slow transmitter.
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'h00A5_0000;
    #1;
    chk("single ready", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("single tx_start", tx_start, 1);
    chk("single tx_data", tx_data, 8'hA5);
    chk("single grant_id", grant_id, 2);
    @(negedge clk);
    #1;
    chk("single start pulse width", tx_start, 0);
    for (int c = 2; c < 100; c++) begin
      tx_busy = 1'b1;
      #1;
      chk("single active during frame", arb_active, 1);
      @(negedge clk);
    end
    tx_done = 1'b1;
    #1;
    chk("single active at done", arb_active, 1);
    @(negedge clk);
    tx_done = 1'b0;
    tx_busy = 1'b0;
    #1;
    chk("single idle after done", arb_active, 0);
    chk("single hold tx_data", tx_data, 8'hA5);

    // Reset mid-frame: rr_ptr must be 0 again afterwards.
    do_reset();
    req_valid = 4'b0010;
    req_data  = 32'h44332211;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    tx_busy = 1'b1;
    @(negedge clk);
    req_valid = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset tx_start", tx_start, 0);
    chk("midreset tx_data", tx_data, 0);
    chk("midreset grant_id", grant_id, 0);
    chk("midreset arb_active", arb_active, 0);
    chk("midreset req_ready", req_ready, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    tx_busy   = 1'b0;
    req_valid = 4'b0110;
    #1;
    chk("postreset ready", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("postreset grant_id", grant_id, 1);
    chk("postreset tx_start", tx_start, 1);
    chk("postreset tx_data", tx_data, 8'h22);

`ifdef UART_ARB_TIMEOUT_EN
    do_reset();
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = 4'b0010;
    tx_busy   = 1'b1;
    @(negedge clk);
    for (int c = 0; c <= 16; c++) begin
      #1;
      chk($sformatf("timeout pulse c%0d", c), arb_timeout, (c == 16) ? 1 : 0);
      if (c == 16) chk("timeout regrant ready", req_ready, 4'b0010);
      @(negedge clk);
    end
    tx_busy = 1'b0;
`endif

    // Randomized traffic against a transaction-level model.
    do_reset();
    pend   = '0;
    for (int i = 0; i < 4; i++) pdat[i] = '0;
    m_rr   = 0;
    m_in   = 0;
    m_age  = 0;
    m_data = '0;
    m_gid  = 0;
    m_to   = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1'b1;
          pdat[i] = 8'($urandom);
        end
      end
      req_valid = pend;
      req_data  = {pdat[3], pdat[2], pdat[1], pdat[0]};
      tx_busy   = 1'($urandom_range(1));
      tx_done   = ($urandom_range(3) == 0);
      #1;
      w = -1;
      if (!m_in) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_rr + k) % 4;
          if (w < 0 && pend[idx]) w = idx;
        end
      end
      e_ready = (w >= 0) ? 4'(1 << w) : 4'b0000;
      chk("rand req_ready", req_ready, e_ready);
      chk("rand tx_start", tx_start, (m_in && m_age == 1) ? 1 : 0);
      chk("rand tx_data", tx_data, m_data);
      chk("rand grant_id", grant_id, m_gid);
      chk("rand arb_active", arb_active, m_in);
      chk("rand arb_timeout", arb_timeout, m_to);
      m_to_n = 0;
      if (w >= 0) begin
        m_data  = pdat[w];
        m_gid   = w;
        m_rr    = (w + 1) % 4;
        m_in    = 1;
        m_age   = 1;
        pend[w] = 1'b0;
      end else if (m_in) begin
        if (m_age >= 2 && tx_done) m_in = 0;
        else if (TO_EN && m_age == TO + 1) begin
          m_in   = 0;
          m_to_n = 1;
        end else m_age++;
      end
      m_to = m_to_n;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
